// File: rtl/column_shift_loader.sv
// rtl/column_shift_loader.sv - serial loader for 2N-1 partial-product columns with delayed result capture
module column_shift_loader #(
    parameter int N       = 29,
    parameter int RES_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clr,
    input  logic [2*N-2:0]     src_in,
    output logic [N*N-1:0]     cols,
    output logic               full,
    input  logic [2*N:0]       cmp_dst,
    output logic [2*N:0]       res,
    output logic               res_vld,
    output logic [15:0]        res_cnt
);

    localparam int C  = 2 * N - 1;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(N);
    localparam logic [CW-1:0] CNT_LOAD = CW'(N - 1);

    function automatic int col_h(input int i);
        return (i < N) ? i + 1 : 2 * N - 1 - i;
    endfunction

    function automatic int col_off(input int i);
        int s;
        s = 0;
        for (int j = 0; j < i; j++) s += col_h(j);
        return s;
    endfunction

    logic              kill;
    logic [CW-1:0]     fill_cnt;
    logic [CW-1:0]     fill_nxt;
    logic              load_ok;
    logic [RES_LAT-1:0] vp;
    logic [RES_LAT:0]  vp_sh;

    assign kill    = rst | clr;
    assign load_ok = en && (fill_cnt >= CNT_LOAD);
    // vp_sh[RES_LAT] is the token leaving the delay line this cycle
    assign vp_sh   = {vp, load_ok};

    always_comb begin
        fill_nxt = fill_cnt;
        if (en && (fill_cnt != CNT_MAX)) fill_nxt = fill_cnt + CW'(1);
    end

    genvar gi;
    generate
        for (gi = 0; gi < C; gi++) begin : g_col
            localparam int H   = col_h(gi);
            localparam int OFF = col_off(gi);
            logic [H-1:0] col_q;

            if (H == 1) begin : g_single
                always_ff @(posedge clk) begin
                    if (kill)    col_q <= '0;
                    else if (en) col_q <= src_in[gi];
                end
            end else begin : g_multi
                always_ff @(posedge clk) begin
                    if (kill)    col_q <= '0;
                    else if (en) col_q <= {col_q[H-2:0], src_in[gi]};
                end
            end

            assign cols[OFF +: H] = col_q;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (kill) begin
            fill_cnt <= '0;
            full     <= 1'b0;
            vp       <= '0;
            res      <= '0;
            res_vld  <= 1'b0;
            res_cnt  <= 16'd0;
        end else begin
            fill_cnt <= fill_nxt;
            full     <= (fill_nxt == CNT_MAX);
            vp       <= vp_sh[RES_LAT-1:0];
            if (vp_sh[RES_LAT]) begin
                res     <= cmp_dst;
                res_vld <= 1'b1;
                res_cnt <= res_cnt + 16'd1;
            end else begin
                res_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_column_shift_loader.sv
// tb/tb_column_shift_loader.sv - scoreboard bench for column_shift_loader (N=4/RES_LAT=3 and N=2/RES_LAT=1)
module tb_column_shift_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // instance A: N=4, RES_LAT=3
    logic        a_rst, a_en, a_clr;
    logic [6:0]  a_src;
    logic [15:0] a_cols;
    logic        a_full;
    logic [8:0]  a_cmp, a_res;
    logic        a_vld;
    logic [15:0] a_cnt;

    // instance B: N=2, RES_LAT=1
    logic        b_rst, b_en, b_clr;
    logic [2:0]  b_src;
    logic [3:0]  b_cols;
    logic        b_full;
    logic [4:0]  b_cmp, b_res;
    logic        b_vld;
    logic [15:0] b_cnt;

    column_shift_loader #(.N(4), .RES_LAT(3)) u_a (
        .clk(clk), .rst(a_rst), .en(a_en), .clr(a_clr), .src_in(a_src),
        .cols(a_cols), .full(a_full), .cmp_dst(a_cmp), .res(a_res),
        .res_vld(a_vld), .res_cnt(a_cnt)
    );

    column_shift_loader #(.N(2), .RES_LAT(1)) u_b (
        .clk(clk), .rst(b_rst), .en(b_en), .clr(b_clr), .src_in(b_src),
        .cols(b_cols), .full(b_full), .cmp_dst(b_cmp), .res(b_res),
        .res_vld(b_vld), .res_cnt(b_cnt)
    );

    int          a_fill = 0;
    logic [15:0] a_rc = 16'd0;
    logic [24:0] a_q[$];
    int          b_fill = 0;
    logic [15:0] b_rc = 16'd0;
    logic [20:0] b_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic a_step(input logic en, input logic clr, input logic rst, input logic [6:0] src);
        logic load;
        load = en && !clr && !rst && (a_fill >= 3);
        a_en = en; a_clr = clr; a_rst = rst; a_src = src;
        @(posedge clk); #1;
        if (rst || clr) begin
            a_q.delete(); a_fill = 0; a_rc = 16'd0;
        end else begin
            if (en && a_fill < 4) a_fill++;
            if (load) begin
                a_rc = a_rc + 16'd1;
                a_q.push_back({a_cmp, a_rc});
            end
        end
    endtask

    task automatic b_step(input logic en, input logic clr, input logic rst, input logic [2:0] src);
        logic load;
        load = en && !clr && !rst && (b_fill >= 1);
        b_en = en; b_clr = clr; b_rst = rst; b_src = src;
        @(posedge clk); #1;
        if (rst || clr) begin
            b_q.delete(); b_fill = 0; b_rc = 16'd0;
        end else begin
            if (en && b_fill < 2) b_fill++;
            if (load) begin
                b_rc = b_rc + 16'd1;
                b_q.push_back({b_cmp, b_rc});
            end
        end
    endtask

    always @(negedge clk) begin
        logic [24:0] e;
        if (a_vld === 1'b1) begin
            if (a_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_unexpected_capture: got res_vld=1 expected 0");
            end else begin
                e = a_q.pop_front();
                chk("a_res", 32'(a_res), 32'(e[24:16]));
                chk("a_res_cnt", 32'(a_cnt), 32'(e[15:0]));
            end
        end
    end

    always @(negedge clk) begin
        logic [20:0] e;
        if (b_vld === 1'b1) begin
            if (b_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected_capture: got res_vld=1 expected 0");
            end else begin
                e = b_q.pop_front();
                chk("b_res", 32'(b_res), 32'(e[20:16]));
                chk("b_res_cnt", 32'(b_cnt), 32'(e[15:0]));
            end
        end
    end

    initial begin
        a_rst = 1'b1; a_en = 1'b0; a_clr = 1'b0; a_src = '0; a_cmp = 9'h0A5;
        b_rst = 1'b1; b_en = 1'b0; b_clr = 1'b0; b_src = '0; b_cmp = 5'h15;

        // reset state
        a_step(0, 0, 1, 0); a_step(0, 0, 1, 0);
        chk("a_rst_cols", 32'(a_cols), 32'h0);
        chk("a_rst_full", 32'(a_full), 32'h0);
        chk("a_rst_res", 32'(a_res), 32'h0);
        chk("a_rst_vld", 32'(a_vld), 32'h0);
        chk("a_rst_cnt", 32'(a_cnt), 32'h0);

        // fill with all ones; full rises on the 4th edge, capture 3 edges later
        for (int i = 0; i < 4; i++) begin
            a_step(1, 0, 0, 7'h7F);
            chk("a_fill_full", 32'(a_full), (i == 3) ? 32'h1 : 32'h0);
            chk("a_fill_vld", 32'(a_vld), 32'h0);
        end
        chk("a_fill_cols", 32'(a_cols), 32'hFFFF);
        a_step(0, 0, 0, 0); chk("a_lat_vld1", 32'(a_vld), 32'h0);
        a_step(0, 0, 0, 0); chk("a_lat_vld2", 32'(a_vld), 32'h0);
        a_step(0, 0, 0, 0); chk("a_lat_vld3", 32'(a_vld), 32'h1);
        a_step(0, 0, 0, 0); chk("a_lat_vld4", 32'(a_vld), 32'h0);

        // bit ordering: oldest sample ends up in the top bit of column 3
        a_step(0, 0, 1, 0);
        a_step(1, 0, 0, 7'h09);
        for (int i = 0; i < 3; i++) a_step(1, 0, 0, 7'h00);
        chk("a_order_cols", 32'(a_cols), 32'h0200);
        chk("a_order_full", 32'(a_full), 32'h1);
        for (int i = 0; i < 4; i++) a_step(0, 0, 0, 0);

        // five shifts give two back-to-back captures
        a_step(0, 0, 1, 0);
        for (int i = 0; i < 5; i++) a_step(1, 0, 0, 7'h7F);
        for (int i = 0; i < 5; i++) a_step(0, 0, 0, 0);
        chk("a_b2b_cnt", 32'(a_cnt), 32'h2);
        chk("a_b2b_res", 32'(a_res), 32'h0A5);

        // clear one cycle after the loading shift flushes the pending capture
        a_step(0, 0, 1, 0);
        for (int i = 0; i < 4; i++) a_step(1, 0, 0, 7'h7F);
        a_step(0, 1, 0, 0);
        for (int i = 0; i < 5; i++) a_step(0, 0, 0, 0);
        chk("a_clr_cnt", 32'(a_cnt), 32'h0);
        chk("a_clr_cols", 32'(a_cols), 32'h0);
        chk("a_clr_full", 32'(a_full), 32'h0);
        chk("a_clr_vld", 32'(a_vld), 32'h0);

        // en toggling: only enabled cycles count toward fill
        a_step(0, 0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            a_step((i % 2) == 0, 0, 0, 7'h7F);
            chk("a_tog_full", 32'(a_full), (i >= 6) ? 32'h1 : 32'h0);
        end
        chk("a_tog_cols", 32'(a_cols), 32'hFFFF);
        for (int i = 0; i < 5; i++) a_step(0, 0, 0, 0);
        chk("a_tog_cnt", 32'(a_cnt), 32'h1);
        chk("a_q_drained", 32'(a_q.size()), 32'h0);

        // N=2 geometry, fill, single-cycle latency and res_cnt wrap
        b_step(0, 0, 1, 0);
        chk("b_rst_cols", 32'(b_cols), 32'h0);
        b_step(1, 0, 0, 3'b111);
        chk("b_geo_cols1", 32'(b_cols), 32'hB);
        chk("b_geo_full1", 32'(b_full), 32'h0);
        b_step(1, 0, 0, 3'b000);
        chk("b_geo_cols2", 32'(b_cols), 32'h4);
        chk("b_geo_full2", 32'(b_full), 32'h1);
        chk("b_geo_vld", 32'(b_vld), 32'h0);
        for (int i = 0; i < 65535; i++) begin
            b_step(1, 0, 0, 3'b101);
            if (i == 0) chk("b_lat_vld", 32'(b_vld), 32'h1);
        end
        b_step(0, 0, 0, 0);
        b_step(0, 0, 0, 0);
        chk("b_wrap_cnt", 32'(b_cnt), 32'h0);
        chk("b_wrap_vld", 32'(b_vld), 32'h0);
        chk("b_q_drained", 32'(b_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
